// File: rtl/bounce_pkg.sv
// Shared types and constants for the bounce counter checker.
package bounce_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_PER_W = 8;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [2:0] {
    ACQ,
    UP,
    TOP1,
    DOWN,
    BOT1
  } state_t;
endpackage

// File: rtl/bounce_checker_if.sv
// Sample bus into the checker plus its status outputs and FSM state for debug.
interface bounce_checker_if
  import bounce_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PER_W = DEF_PER_W
);
  // valid qualifies in; there is no ready: every valid sample is accepted that cycle.
  logic             valid;
  logic [WIDTH-1:0] in;
  logic             clr;
  logic             locked;
  logic             dir;
  logic             top;
  logic             err;
  logic [WIDTH-1:0] err_val;
  logic [PER_W-1:0] periods;
  state_t           state;

  modport master (
    output valid, in, clr,
    input  locked, dir, top, err, err_val, periods, state
  );

  modport slave (
    input  valid, in, clr,
    output locked, dir, top, err, err_val, periods, state
  );
endinterface

// File: rtl/bounce_stats.sv
// Saturating period counter and sticky error capture; clr yields to same-cycle events.
module bounce_stats #(
  parameter int WIDTH = 4,
  parameter int PER_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             mis,
  input  logic [WIDTH-1:0] sample,
  input  logic             clr,
  output logic             err,
  output logic [WIDTH-1:0] err_val,
  output logic [PER_W-1:0] periods
);
  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);
  localparam logic [PER_W-1:0] PER_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_val <= '0;
      periods <= '0;
    end else begin
      // A clear in the same cycle as a mismatch still records the new offender.
      if (mis) begin
        err <= 1'b1;
        if (!err || clr) err_val <= sample;
      end else if (clr) begin
        err     <= 1'b0;
        err_val <= '0;
      end

      if (clr) periods <= inc ? PER_ONE : '0;
      else if (inc && periods != PER_MAX) periods <= periods + PER_ONE;
    end
  end
endmodule

// File: rtl/bounce_checker.sv
// Locks onto the 0..MAX,MAX..0 bounce pattern and flags samples that break it.
module bounce_checker
  import bounce_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PER_W = DEF_PER_W
) (
  input  logic            clk,
  input  logic            rst_n,
  bounce_checker_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           st;
  state_t           nxt_st;
  logic             p_vld;
  logic [WIDTH-1:0] p;
  logic             up_ok;
  logic             dn_ok;
  logic             mis;
  logic             inc;
  logic             top_ev;

  // The +1/-1 compares are only meaningful away from the ends of the range.
  assign up_ok = (p != MAX)  && (bus.in == p + ONE);
  assign dn_ok = (p != ZERO) && (bus.in == p - ONE);

  always_comb begin
    nxt_st = st;
    mis    = 1'b0;
    inc    = 1'b0;
    top_ev = 1'b0;
    if (bus.valid) begin
      case (st)
        ACQ: begin
          if (p_vld) begin
            if (up_ok)                              nxt_st = (bus.in == MAX)  ? TOP1 : UP;
            else if (dn_ok)                         nxt_st = (bus.in == ZERO) ? BOT1 : DOWN;
            else if (bus.in == p && p == MAX)       nxt_st = DOWN;
            else if (bus.in == p && p == ZERO)      nxt_st = UP;
          end
        end
        UP: begin
          if (up_ok) nxt_st = (bus.in == MAX) ? TOP1 : UP;
          else       mis = 1'b1;
        end
        TOP1: begin
          if (bus.in == MAX) begin
            nxt_st = DOWN;
            top_ev = 1'b1;
          end else begin
            mis = 1'b1;
          end
        end
        DOWN: begin
          if (dn_ok) nxt_st = (bus.in == ZERO) ? BOT1 : DOWN;
          else       mis = 1'b1;
        end
        BOT1: begin
          if (bus.in == ZERO) begin
            nxt_st = UP;
            inc    = 1'b1;
          end else begin
            mis = 1'b1;
          end
        end
        default: nxt_st = ACQ;
      endcase
      if (mis) nxt_st = ACQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ACQ;
      p_vld      <= 1'b0;
      p          <= '0;
      bus.locked <= 1'b0;
      bus.dir    <= DIR_UP;
      bus.top    <= 1'b0;
    end else begin
      bus.top <= top_ev;
      if (bus.valid) begin
        st         <= nxt_st;
        p_vld      <= 1'b1;
        p          <= bus.in;
        bus.locked <= (nxt_st != ACQ);
        // Direction holds through ACQ so it still shows the last tracked slope.
        case (nxt_st)
          UP, BOT1:   bus.dir <= DIR_UP;
          TOP1, DOWN: bus.dir <= DIR_DOWN;
          default:    bus.dir <= bus.dir;
        endcase
      end
    end
  end

  assign bus.state = st;

  bounce_stats #(
    .WIDTH(WIDTH),
    .PER_W(PER_W)
  ) u_stats (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (inc),
    .mis     (mis),
    .sample  (bus.in),
    .clr     (bus.clr),
    .err     (bus.err),
    .err_val (bus.err_val),
    .periods (bus.periods)
  );
endmodule

// File: tb/tb_bounce_checker.sv
// Randomized and directed bench for bounce_checker against a phase-based reference model.
module tb_bounce_checker;
  import bounce_pkg::*;

  localparam int W  = 4;
  localparam int OW = 18;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bounce_checker_if #(.WIDTH(W), .PER_W(8)) bus ();
  bounce_checker_if #(.WIDTH(W), .PER_W(2)) bus2 ();

  bounce_checker #(.WIDTH(W), .PER_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bounce_checker #(.WIDTH(W), .PER_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int total = 0;
  int bad   = 0;
  int n_top = 0;

  logic [OW-1:0] exp_q[$];

  // Reference model: position k in the 32-sample period, value f(k).
  bit m_have_p, m_locked, m_dir, m_top, m_err;
  int m_p, m_k, m_err_val, m_per, m_per2;

  function automatic int bval(input int k);
    return (k < 16) ? k : 31 - k;
  endfunction

  task automatic check_eq(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_have_p = 0; m_locked = 0; m_dir = 0; m_top = 0; m_err = 0;
    m_p = 0; m_k = 0; m_err_val = 0; m_per = 0; m_per2 = 0;
  endtask

  task automatic model_step(input bit v, input int s, input bit c);
    bit mis;
    bit inc;
    int nk;
    mis = 0;
    inc = 0;
    m_top = 0;
    if (v) begin
      if (m_locked) begin
        nk = (m_k + 1) % 32;
        if (s == bval(nk)) begin
          m_k = nk;
          if (nk == 16) m_top = 1;
          if (nk == 0) inc = 1;
        end else begin
          mis = 1;
          m_locked = 0;
        end
      end else if (m_have_p) begin
        for (int k = 0; k < 32; k++) begin
          if (bval((k + 31) % 32) == m_p && bval(k) == s) begin
            m_locked = 1;
            m_k = k;
          end
        end
      end
      m_have_p = 1;
      m_p = s;
      if (m_locked) m_dir = (m_k >= 15 && m_k <= 30);
    end
    if (mis) begin
      if (!m_err || c) m_err_val = s;
      m_err = 1;
    end else if (c) begin
      m_err = 0;
      m_err_val = 0;
    end
    if (c) begin
      m_per  = inc ? 1 : 0;
      m_per2 = inc ? 1 : 0;
    end else if (inc) begin
      if (m_per < 255) m_per++;
      if (m_per2 < 3) m_per2++;
    end
  endtask

  task automatic check_outputs(input logic [OW-1:0] e);
    check_eq("locked",   bus.locked,   e[17]);
    check_eq("dir",      bus.dir,      e[16]);
    check_eq("top",      bus.top,      e[15]);
    check_eq("err",      bus.err,      e[14]);
    check_eq("err_val",  bus.err_val,  e[13:10]);
    check_eq("periods",  bus.periods,  e[9:2]);
    check_eq("periods2", bus2.periods, e[1:0]);
    check_eq("locked2",  bus2.locked,  e[17]);
  endtask

  function automatic logic [OW-1:0] model_pack();
    return {m_locked, m_dir, m_top, m_err, W'(m_err_val), 8'(m_per), 2'(m_per2)};
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] s, input logic c);
    bus.valid  = v; bus.in  = s; bus.clr  = c;
    bus2.valid = v; bus2.in = s; bus2.clr = c;
  endtask

  task automatic step(input logic v, input logic [W-1:0] s, input logic c);
    @(negedge clk);
    drive(v, s, c);
    model_step(v, int'(s), c);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    check_outputs(exp_q.pop_front());
    if (bus.top) n_top++;
  endtask

  // Reset lands between clock edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0);
    model_reset();
    #1;
    check_outputs(model_pack());
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_healthy(input int k0, input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      if (toggle) step(1'b0, W'($urandom_range(0, 15)), 1'b0);
      step(1'b1, W'(bval((k0 + i) % 32)), 1'b0);
    end
  endtask

  initial begin
    int k;
    bit v;
    bit c;
    logic [W-1:0] s;

    drive(1'b0, '0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Healthy run from 0
    n_top = 0;
    run_healthy(0, 70, 1'b0);
    check_eq("hlth_periods", bus.periods, 2);
    check_eq("hlth_tops", n_top, 2);

    // Mismatch in UP, re-acquire, second mismatch keeps first capture
    do_reset();
    run_healthy(0, 7, 1'b0);
    step(1'b1, 4'd9, 1'b0);
    check_eq("inj_err", bus.err, 1);
    check_eq("inj_err_val", bus.err_val, 9);
    check_eq("inj_locked", bus.locked, 0);
    step(1'b1, 4'd10, 1'b0);
    step(1'b1, 4'd11, 1'b0);
    check_eq("reacq_locked", bus.locked, 1);
    step(1'b1, 4'd12, 1'b0);
    step(1'b1, 4'd3, 1'b0);
    check_eq("sticky_err_val", bus.err_val, 9);

    // Start at the peak: no Top until the following peak
    do_reset();
    n_top = 0;
    run_healthy(15, 2, 1'b0);
    check_eq("mid_locked", bus.locked, 1);
    check_eq("mid_dir", bus.dir, 1);
    run_healthy(17, 31, 1'b0);
    check_eq("mid_no_top", n_top, 0);
    run_healthy(48, 3, 1'b0);
    check_eq("mid_next_top", n_top, 1);

    // Valid toggling every other cycle
    do_reset();
    n_top = 0;
    run_healthy(0, 70, 1'b1);
    check_eq("tog_periods", bus.periods, 2);
    check_eq("tog_tops", n_top, 2);

    // Clr together with a mismatch, then clr alone
    do_reset();
    run_healthy(0, 55, 1'b0);
    step(1'b1, 4'd4, 1'b1);
    check_eq("clrmis_err", bus.err, 1);
    check_eq("clrmis_err_val", bus.err_val, 4);
    check_eq("clrmis_periods", bus.periods, 0);
    step(1'b1, 4'd3, 1'b1);
    check_eq("clr_err", bus.err, 0);
    check_eq("clr_err_val", bus.err_val, 0);

    // Saturation of the narrow counter, then reset mid-DOWN
    do_reset();
    run_healthy(0, 161, 1'b0);
    check_eq("sat_periods2", bus2.periods, 3);
    check_eq("sat_periods", bus.periods, 5);
    run_healthy(161, 20, 1'b0);
    do_reset();

    // Random mix of healthy samples, glitches, gaps and clears
    k = 0;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = v && ($urandom_range(0, 19) == 0);
      if (!v) begin
        s = W'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) begin
        s = W'($urandom_range(0, 15));
      end else begin
        s = W'(bval(k % 32));
        k++;
      end
      step(v, s, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bounce_checker.md
# bounce_checker

Downstream monitor for the 4-bit bounce counter stage (sequence 0, 1, …, 15, 15, 14, …, 0, 0, 1, …).
- Samples the counter value on each valid cycle and locks onto the bounce pattern.
- Reports the current direction, turnaround events and completed periods.
- Flags any sample that breaks the pattern with a sticky error that captures the offending value.
- Used in system bring-up and in benches to qualify the counter stage in place.

## Interface
Parameters:
- WIDTH, 4: sample width; MAX = 2**WIDTH-1.
- PER_W, 8: width of completed-period counter.

Ports:
- Clock  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Valid  in  1  In is a sample this cycle; when low, no state changes.
- In  in  WIDTH  counter value from upstream stage.
- Clr  in  1  synchronous clear of Err, Err_Val, Periods.
- Locked  out  1  checker is tracking the pattern.
- Dir  out  1  expected next step: 0 = up/hold-at-0, 1 = down/hold-at-MAX.
- Top  out  1  one-cycle pulse: second MAX accepted.
- Err  out  1  sticky mismatch flag.
- Err_Val  out  WIDTH  first offending sample since last clear.
- Periods  out  PER_W  completed periods (second 0 accepted), saturating at all-ones.

## Operation
- State machine has five states: ACQ, UP, TOP1, DOWN, BOT1. Register P holds the last accepted sample.
- **ACQ**: entered from reset or after a mismatch.
  - With no prior sample, the first valid sample is stored in P and the state stays ACQ.
  - Otherwise, for sample s:
    - s==P+1 (P<MAX) → UP if s<MAX, else TOP1.
    - s==P-1 (P>0) → DOWN if s>0, else BOT1.
    - s==P==MAX → DOWN.
    - s==P==0 → UP.
    - Anything else → stay ACQ.
  - P←s in every case.
- **UP** expects P+1. On match, P←s; if s==MAX → TOP1.
- **TOP1** expects MAX. On match → DOWN and pulse Top.
- **DOWN** expects P-1. On match, P←s; if s==0 → BOT1.
- **BOT1** expects 0. On match → UP; Periods increments, holding at 2**PER_W-1.
- **Mismatch** in any locked state:
  - Err←1.
  - Err_Val←s, only if Err was 0.
  - State → ACQ with P←s, so the checker re-acquires from the bad sample.
- Outputs by state:
  - Locked = (state≠ACQ).
  - Dir is 0 in UP/BOT1 and 1 in DOWN/TOP1. In ACQ it holds its last value.
- Arithmetic is WIDTH-bit with no wrap. P+1 is never compared when P==MAX, and P-1 never when P==0; those paths are covered by the explicit equality rules above.
- **Clr** zeroes Err, Err_Val and Periods. It does not affect the state machine, P, Dir or Locked.
- **Clr and event in the same cycle**:
  - Clr with a mismatch: Err=1, Err_Val=s.
  - Clr with a BOT1 match: Periods=1.

## Timing
- Reset values: state ACQ, P-valid 0, P 0, Locked 0, Dir 0, Top 0, Err 0, Err_Val 0, Periods 0.
- All outputs are registered. Each reflects the Valid sample accepted at edge N, visible from edge N onward, i.e. in the cycle after the sample was presented.
- Top is high for exactly one clock per accepted TOP1 match, even if Valid stays high.
- Valid low freezes all state and outputs, except Top, which returns to 0.
- Reset asserted mid-sequence clears everything immediately (asynchronous). After release, lock needs two valid samples.
- Continuous valid samples from a healthy counter:
  - Locked rises after the 2nd sample.
  - Periods increments once per 32 samples.

## Structure
- Package bounce_pkg:
  - state enum (ACQ, UP, TOP1, DOWN, BOT1);
  - DIR_UP/DIR_DOWN constants;
  - default WIDTH/PER_W.
- Sub-module bounce_stats: saturating Periods counter, sticky Err/Err_Val capture and Clr priority logic. Driven by one-cycle inc/mismatch strobes from the FSM.
- bounce_checker holds the FSM, P register, expectation compare and Dir/Top/Locked.

## Test plan
- Reset, then drive a healthy counter for 70 cycles starting at 0 → Locked=1 after the 2nd sample, Top pulses at the 2nd 15, Periods=2 after the second 0-0 pair, Err=0 throughout.
- Locked in UP at P=6, inject 9 → Err=1, Err_Val=9, Locked=0. Resume at 10, 11 → Locked=1 in UP. Inject 3 later → Err_Val stays 9.
- Start mid-sequence at 15, 15, 14 → Locked after 2nd 15, Dir=1, next Top does not pulse until the following peak.
- Valid toggled every other cycle with a healthy sequence on valid cycles → identical Periods/Top counts as the continuous run. No change while Valid=0.
- Assert Clr in the same cycle as a mismatch (sample 4 where 8 expected) → Err=1, Err_Val=4, Periods=0. Then Clr alone → Err=0, Err_Val=0.
- PER_W=2, run 5 periods → Periods saturates at 3. Assert Reset low mid-DOWN → all outputs 0 that cycle.
